fft_sink_driver: RTL and testbench
==================================

# fft_sink_driver

Frames the free-running audio sample stream into FFT-sized packets and drives the sink side of the `fft` core's Avalon-ST interface. It sits between the codec receive path and `fft`. It buffers samples in a FIFO and starts a frame only once a full frame is buffered, so every frame reaches the FFT with no valid gaps. It also honours `sink_ready` backpressure, flags dropped samples, and can optionally remove DC offset.

## Interface
- `IN_W`, 24: signed input sample width.
- `OUT_W`, 32: `sink_real`/`sink_imag` width; must be ≥ `IN_W`.
- `FFT_PTS`, 1024: points per frame; power of two, ≤ 1024.
- `FIFO_AW`, 11: FIFO address width; depth is 2^`FIFO_AW`, and depth must be ≥ 2·`FFT_PTS`.
- `DC_SHIFT`, 10: DC-tracker time constant (2^`DC_SHIFT` samples); used only when DC removal is compiled in.

Ports (clock and reset first):
- `clk`  in  1  single clock for the block.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  one sample strobe; no backpressure toward the codec.
- `in_data`  in  `IN_W`  signed sample.
- `enable`  in  1  permits new frames to start.
- `clr_overflow`  in  1  synchronous clear of `overflow`.
- `sink_valid`  out  1  to `fft`.
- `sink_ready`  in  1  from `fft`.
- `sink_error`  out  2  constant 0.
- `sink_sop`  out  1  first point of a frame.
- `sink_eop`  out  1  last point of a frame.
- `sink_real`  out  `OUT_W`  sign-extended sample.
- `sink_imag`  out  `OUT_W`  constant 0.
- `fftpts_in`  out  11  constant `FFT_PTS`.
- `overflow`  out  1  sticky flag: a sample was dropped.
- `frame_cnt`  out  16  number of frames fully sent; wraps.

## Operation
- **FIFO write.** A write occurs when `in_valid` is high. If `level == depth` in that cycle, the sample is dropped and `overflow` is set, even if a read happens in the same cycle.
- **`overflow`.** `clr_overflow` clears it. If a set and a clear happen in the same cycle, the set wins.
- **FSM states:** IDLE, LOAD, STREAM.
  - IDLE → LOAD when `enable` is high and `level ≥ FFT_PTS`.
  - LOAD: issue one FIFO read and set the point counter to 0. Always → STREAM next cycle.
  - STREAM: `sink_valid` = 1. A transfer occurs when `sink_valid` and `sink_ready` are both high. On each transfer the next FIFO word is prefetched and the counter increments.
  - `sink_sop` = (counter == 0). `sink_eop` = (counter == `FFT_PTS`−1).
  - On the eop transfer, `frame_cnt` increments. The FSM then goes → LOAD if `enable` is high and `level ≥ FFT_PTS`, otherwise → IDLE.
- **`enable`.** Deasserting `enable` mid-frame does not truncate the frame; the current frame completes.
- **Output sample.** `sink_real` = `in_data` sign-extended to `OUT_W` (or DC-corrected, see Configuration).
- **Counter width.** The point counter is `$clog2(FFT_PTS)` bits wide.

## Timing
- **Reset values:** all outputs are 0 except `fftpts_in` (= `FFT_PTS`); FIFO empty; FSM in IDLE; counters 0.
- **Reset mid-frame** aborts the frame immediately. `fft` shares `reset_n`, so no partial frame is left pending.
- **Level update:** a sample written at cycle t counts in `level` at t+1.
- **Frame start latency:** minimum 2 cycles from the cycle `level` reaches `FFT_PTS` to `sink_sop` valid (IDLE → LOAD → STREAM). Back-to-back frames have exactly one idle cycle (LOAD).
- **Backpressure:** while `sink_valid` is high and `sink_ready` is low, `sink_real`, `sink_sop` and `sink_eop` hold stable. Ready latency is 0.
- **Throughput:** one point per cycle while `sink_ready` is high.

## Configuration
- **`FFT_DRV_DC_REMOVE_EN` defined:**
  - Keep an accumulator `acc`, width `IN_W`+`DC_SHIFT`, reset to 0.
  - Per accepted input sample: `acc += x − (acc >>> DC_SHIFT)`.
  - The stored sample is `x − (acc >>> DC_SHIFT)`, computed from pre-update `acc`, saturated to `IN_W`.
  - One extra register stage on the write path, so input-to-level latency becomes 2 cycles.
- **Undefined:** samples are stored unmodified and there is no accumulator.

## Structure
- Shared package `fft_drv_pkg` holds: the FSM state enum, `FFTPTS_W` = 11, and the saturate function.
- One sub-module, `sync_fifo` (parameterised width/depth, exposes `level`), is natural.
- The FSM, counters and output register live in `fft_sink_driver`.

## Test plan
- **Single frame, no backpressure.** Feed 1024 samples with values 0..1023, `enable`=1, `sink_ready`=1. Expect:
  - `sink_sop` with `sink_real` = 0.
  - 1024 contiguous valid cycles.
  - `sink_eop` with `sink_real` = 1023; `frame_cnt` = 1.
- **Backpressure.** Toggle `sink_ready` randomly at 50%. Expect the output sequence unchanged and data stable on every stalled cycle.
- **Overflow.** `sink_ready` = 0, push 2049 samples. Expect `overflow` = 1 and `level` = 2048. Assert `clr_overflow`: `overflow` → 0.
- **Enable dropped mid-frame.** Drop `enable` at point 500. Expect the frame to finish with eop at point 1023, then IDLE with 1500 samples buffered and no new sop.
- **Reset mid-frame.** Assert `reset_n` low at point 300. Expect all outputs 0 the same cycle and a clean sop on the next full frame.
- **DC removal (`FFT_DRV_DC_REMOVE_EN`).** Drive a constant input of 1000. Expect `sink_real` to decay toward 0, with |value| < 8 after 8·2^`DC_SHIFT` samples.

Source files
------------

// File: rtl/fft_drv_pkg.sv
// Shared definitions for fft_sink_driver: FSM state encoding, the fixed
// width of the fft core's point-count port, and a generic saturator.
package fft_drv_pkg;

    localparam int FFTPTS_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    // Clamp a signed value into the range of a w-bit two's-complement number.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and an occupancy count.
// Writes are refused when full, regardless of a read in the same cycle.
module sync_fifo #(
    parameter int W  = 24,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [AW:0]   level,
    output logic          full
);

    localparam logic [AW:0] DEPTH = (AW + 1)'(1 << AW);

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;

    assign full  = (level == DEPTH);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && (level != '0);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    // rd_data only moves on a read, so it doubles as the stalled-output hold register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rd_data <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fft_sink_driver.sv
// Frames the audio sample stream into gap-free FFT packets on the fft sink port.
// Optional DC removal on the write path is compiled in with FFT_DRV_DC_REMOVE_EN.
module fft_sink_driver
    import fft_drv_pkg::*;
#(
    parameter int IN_W     = 24,
    parameter int OUT_W    = 32,
    parameter int FFT_PTS  = 1024,
    parameter int FIFO_AW  = 11,
    parameter int DC_SHIFT = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [IN_W-1:0]      in_data,
    input  logic                 enable,
    input  logic                 clr_overflow,
    output logic                 sink_valid,
    input  logic                 sink_ready,
    output logic [1:0]           sink_error,
    output logic                 sink_sop,
    output logic                 sink_eop,
    output logic [OUT_W-1:0]     sink_real,
    output logic [OUT_W-1:0]     sink_imag,
    output logic [FFTPTS_W-1:0]  fftpts_in,
    output logic                 overflow,
    output logic [15:0]          frame_cnt
);

    localparam int CNT_W = (FFT_PTS > 1) ? $clog2(FFT_PTS) : 1;
    localparam logic [FIFO_AW:0] PTS_LVL  = (FIFO_AW + 1)'(FFT_PTS);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(FFT_PTS - 2);

    if (OUT_W < IN_W || FFT_PTS < 2 || FFT_PTS > 1024 ||
        (1 << FIFO_AW) < 2 * FFT_PTS || DC_SHIFT < 1) begin : g_bad_params
        $error("fft_sink_driver: illegal parameter combination");
    end

    logic             wr_en;
    logic [IN_W-1:0]  wr_data;
    logic             rd_en;
    logic [IN_W-1:0]  rd_data;
    logic [FIFO_AW:0] level;
    logic             fifo_full;
    logic             xfer;
    logic             start_ok;
    state_t           state;
    logic [CNT_W-1:0] cnt;

`ifdef FFT_DRV_DC_REMOVE_EN
    localparam int ACC_W = IN_W + DC_SHIFT;

    logic signed [ACC_W-1:0] acc;
    logic signed [IN_W-1:0]  dc_est;
    logic signed [IN_W:0]    diff;

    // acc tracks DC scaled by 2^DC_SHIFT; the stored sample uses the pre-update estimate.
    assign dc_est = IN_W'(acc >>> DC_SHIFT);
    assign diff   = $signed({in_data[IN_W-1], in_data}) - $signed({dc_est[IN_W-1], dc_est});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc     <= '0;
            wr_en   <= 1'b0;
            wr_data <= '0;
        end else begin
            wr_en <= in_valid;
            if (in_valid) begin
                acc     <= acc + ACC_W'(diff);
                wr_data <= IN_W'(saturate(64'(diff), IN_W));
            end
        end
    end
`else
    assign wr_en   = in_valid;
    assign wr_data = in_data;
`endif

    sync_fifo #(
        .W  (IN_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .level   (level),
        .full    (fifo_full)
    );

    assign xfer     = sink_valid && sink_ready;
    assign start_ok = enable && (level >= PTS_LVL);
    // LOAD fetches point 0; every non-final transfer prefetches the next point.
    assign rd_en    = (state == ST_LOAD) || (xfer && !sink_eop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sink_valid <= 1'b0;
            sink_sop   <= 1'b0;
            sink_eop   <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    state      <= ST_STREAM;
                    cnt        <= '0;
                    sink_valid <= 1'b1;
                    sink_sop   <= 1'b1;
                    sink_eop   <= 1'b0;
                end
                ST_STREAM: begin
                    if (xfer) begin
                        if (sink_eop) begin
                            frame_cnt  <= frame_cnt + 16'd1;
                            sink_valid <= 1'b0;
                            sink_sop   <= 1'b0;
                            sink_eop   <= 1'b0;
                            state      <= start_ok ? ST_LOAD : ST_IDLE;
                        end else begin
                            cnt      <= cnt + CNT_W'(1);
                            sink_sop <= 1'b0;
                            sink_eop <= (cnt == PRE_LAST);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (wr_en && fifo_full) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    assign sink_real  = OUT_W'($signed(rd_data));
    assign sink_imag  = '0;
    assign sink_error = 2'b00;
    assign fftpts_in  = FFTPTS_W'(FFT_PTS);

endmodule

// File: tb/tb_fft_sink_driver.sv
// Directed-plus-random bench for fft_sink_driver against a queue-based reference
// model; FFT_DRV_DC_REMOVE_EN switches the model to the DC-corrected sample values.
module tb_fft_sink_driver;

    localparam int IN_W   = 24;
    localparam int OUT_W  = 32;
    localparam int PTS    = 1024;
    localparam int AW     = 11;
    localparam int DEPTH  = 2048;
    localparam int DCS    = 10;
`ifdef FFT_DRV_DC_REMOVE_EN
    localparam int WR_LAT = 2;
`else
    localparam int WR_LAT = 1;
`endif

    logic              clk;
    logic              reset_n;
    logic              in_valid;
    logic [IN_W-1:0]   in_data;
    logic              enable;
    logic              clr_overflow;
    logic              sink_valid;
    logic              sink_ready;
    logic [1:0]        sink_error;
    logic              sink_sop;
    logic              sink_eop;
    logic [OUT_W-1:0]  sink_real;
    logic [OUT_W-1:0]  sink_imag;
    logic [10:0]       fftpts_in;
    logic              overflow;
    logic [15:0]       frame_cnt;

    fft_sink_driver #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .FFT_PTS  (PTS),
        .FIFO_AW  (AW),
        .DC_SHIFT (DCS)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .enable       (enable),
        .clr_overflow (clr_overflow),
        .sink_valid   (sink_valid),
        .sink_ready   (sink_ready),
        .sink_error   (sink_error),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_real    (sink_real),
        .sink_imag    (sink_imag),
        .fftpts_in    (fftpts_in),
        .overflow     (overflow),
        .frame_cnt    (frame_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [IN_W-1:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          pt = 0;
    int          frames = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    int          valid_cycles = 0;
    int          sop_cyc = 0;
    int          eop_cyc = 0;
    bit          obs_valid;
    bit          hold = 0;
    logic [33:0] held;
    longint      m_acc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] sext(input logic [IN_W-1:0] x);
        return {{(OUT_W - IN_W){x[IN_W-1]}}, x};
    endfunction

    // Reference: every strobed sample enters the queue unless the buffer already holds DEPTH.
    task automatic model_push(input logic [IN_W-1:0] x);
        logic [IN_W-1:0] stored;
`ifdef FFT_DRV_DC_REMOVE_EN
        longint xs, diff, lim, v;
        xs   = longint'($signed(x));
        diff = xs - (m_acc >>> DCS);
        lim  = longint'(1) <<< (IN_W - 1);
        if (diff > lim - 1)   stored = IN_W'(lim - 1);
        else if (diff < -lim) stored = IN_W'(-lim);
        else                  stored = IN_W'(diff);
        v     = m_acc + diff;
        m_acc = (v <<< (64 - IN_W - DCS)) >>> (64 - IN_W - DCS);
`else
        stored = x;
`endif
        if (exp_q.size() < DEPTH) exp_q.push_back(stored);
    endtask

    // One clock: observe and score outputs at the falling edge, then drive the next inputs.
    task automatic step(input bit iv, input logic [IN_W-1:0] d, input bit clr);
        bit rdy;
        logic [IN_W-1:0] x;
        @(negedge clk);
        cyc++;
        obs_valid = sink_valid;
        check("frame_cnt", frame_cnt, frames);
        if (hold && sink_valid) check("stall_hold", {sink_real, sink_sop, sink_eop}, held);
        hold = 0;
        rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        sink_ready = rdy;
        if (sink_valid) begin
            valid_cycles++;
            if (sink_sop) sop_cyc = cyc;
            if (sink_eop) eop_cyc = cyc;
            if (rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", sink_valid, 0);
                end else begin
                    x = exp_q.pop_front();
                    check("data", sink_real, sext(x));
                    check("sop", sink_sop, pt == 0);
                    check("eop", sink_eop, pt == PTS - 1);
                    pt++;
                    if (pt == PTS) begin
                        pt = 0;
                        frames++;
                    end
                end
            end else begin
                hold = 1;
                held = {sink_real, sink_sop, sink_eop};
            end
        end
        in_valid     = iv;
        in_data      = d;
        clr_overflow = clr;
        if (iv) model_push(d);
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) step(1'b1, IN_W'($urandom), 1'b0);
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (frames < n && k < budget) begin
            step(1'b0, '0, 1'b0);
            k++;
        end
        step(1'b0, '0, 1'b0);
        check(tag, frame_cnt, n);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, sink_valid, 0);
        check({tag, "_sop"}, sink_sop, 0);
        check({tag, "_eop"}, sink_eop, 0);
        check({tag, "_real"}, sink_real, 0);
        check({tag, "_imag"}, sink_imag, 0);
        check({tag, "_error"}, sink_error, 0);
        check({tag, "_fftpts"}, fftpts_in, PTS);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        int k;
        reset_n      = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        enable       = 1'b0;
        clr_overflow = 1'b0;
        sink_ready   = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        check("reset_level", dut.u_fifo.level, 0);
        reset_n = 1'b1;

        // Single frame of a ramp, no backpressure.
        enable   = 1'b1;
        rdy_mode = 0;
        for (int i = 0; i < PTS; i++) step(1'b1, IN_W'(i), 1'b0);
        lat = 0;
        do begin
            step(1'b0, '0, 1'b0);
            lat++;
        end while (!obs_valid && lat < 10);
        check("sop_latency", lat, WR_LAT + 2);
        wait_frames(1, 1100, "frame1_done");
        check("contiguous_valid", valid_cycles, PTS);
        check("sop_to_eop", eop_cyc - sop_cyc, PTS - 1);

        // Random data under random 50% backpressure.
        rdy_mode = 1;
        push_rand(PTS);
        wait_frames(2, 6000, "bp_frame_done");

        // Enable dropped mid-frame: frame completes, the rest stays buffered.
        rdy_mode = 0;
        for (int i = 0; i < PTS + 1500; i++) begin
            step(1'b1, IN_W'($urandom), 1'b0);
            if (frames == 2 && pt > 500) enable = 1'b0;
        end
        valid_cycles = 0;
        run_idle(40);
        check("no_new_sop", valid_cycles, 0);
        check("enable_drop_frames", frame_cnt, 3);
        check("level_1500", dut.u_fifo.level, 1500);
        enable = 1'b1;
        wait_frames(4, 1200, "drain_frame");

        // Overflow with the sink stalled and no frame starting.
        enable   = 1'b0;
        rdy_mode = 2;
        push_rand(DEPTH - exp_q.size());
        run_idle(WR_LAT);
        check("ovf_before_full", overflow, 0);
        check("level_full", dut.u_fifo.level, DEPTH);
        push_rand(1);
        run_idle(WR_LAT);
        check("overflow_set", overflow, 1);
        check("level_stay_full", dut.u_fifo.level, DEPTH);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        check("overflow_clr", overflow, 0);
        for (int i = 0; i < WR_LAT; i++) step(i == 0, IN_W'($urandom), i == WR_LAT - 1);
        step(1'b0, '0, 1'b0);
        check("set_wins_clear", overflow, 1);
        step(1'b0, '0, 1'b1);
        enable   = 1'b1;
        rdy_mode = 0;
        wait_frames(6, 2600, "ovf_drain");
        check("drained_level", dut.u_fifo.level, 0);
        check("overflow_cleared", overflow, 0);

        // Reset in the middle of a frame.
        push_rand(PTS);
        k = 0;
        while (pt < 300 && k < 2000) begin
            step(1'b0, '0, 1'b0);
            k++;
        end
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        pt     = 0;
        frames = 0;
        hold   = 0;
        m_acc  = 0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        check("midreset_level", dut.u_fifo.level, 0);
        push_rand(PTS);
        wait_frames(1, 1200, "post_reset_frame");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
